// File: rtl/vm_dispense_ctrl.sv
// vm_dispense_ctrl
// Output-side controller for the vending machine. It watches the product
// code and change count coming out of vm, pulses the selected product motor,
// and then hands the owed 10 Rs coins to the coin ejector one at a time using
// a request/acknowledge handshake. One vend that arrives while busy is held
// in a single pending slot. Ejector timeouts and dropped vends are flagged.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   out[2:0]    product code from vm: 0 none, 1..4 products, 5..7 invalid
//   change[1:0] number of 10 Rs coins to return, valid together with out
//   coin_ack    ejector accepted the coin currently being requested
//   motor_en    one-hot motor drive, bit k-1 runs the motor for product k
//   coin_eject  coin-eject request to the ejector
//   busy        registered: controller not idle or pending slot occupied
//   jam         sticky: ejector never acknowledged within ACK_TIMEOUT cycles
//   overflow    sticky: a vend was dropped because the pending slot was full
//   vend_count  number of vends started, wraps 255 -> 0

module vm_dispense_ctrl #(
   parameter int MOTOR_CYCLES = 4,
   parameter int COIN_GAP     = 2,
   parameter int ACK_TIMEOUT  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] out,
   input  logic [1:0] change,
   input  logic       coin_ack,
   output logic [3:0] motor_en,
   output logic       coin_eject,
   output logic       busy,
   output logic       jam,
   output logic       overflow,
   output logic [7:0] vend_count
);

   typedef enum logic [2:0] {
      IDLE,
      MOTOR,
      EJECT,
      GAP,
      JAM
   } state_t;

   // One shared down-the-phase counter serves every timed state; it always
   // restarts at zero on a state entry, so each phase ends on its *_LAST value.
   localparam logic [15:0] MOTOR_LAST = 16'(MOTOR_CYCLES - 1);
   localparam logic [15:0] GAP_LAST   = 16'(COIN_GAP - 1);
   localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [2:0]  out_q;
   logic [2:0]  code_q, code_d;
   logic [1:0]  coins_q, coins_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pendValid_q, pendValid_d;
   logic [2:0]  pendCode_q, pendCode_d;
   logic [1:0]  pendCoins_q, pendCoins_d;
   logic        overflow_q, overflow_d;
   logic        busy_q;
   logic        jam_q;
   logic [7:0]  vendCount_q;

   logic        vendEvent;
   logic        startVend;
   logic        takePending;
   logic        finishVend;

   // A vend is the first cycle a valid product code appears after a zero.
   assign vendEvent = (out >= 3'd1) && (out <= 3'd4) && (out_q == 3'd0);

   // Next-state logic. The per-state case decides where the current vend is
   // going; the shared tail then handles chaining into the pending vend and
   // filling the pending slot, so that a slot consumed on this cycle can be
   // refilled by a new event on the same cycle without raising overflow.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      coins_d     = coins_q;
      cnt_d       = cnt_q;
      pendValid_d = pendValid_q;
      pendCode_d  = pendCode_q;
      pendCoins_d = pendCoins_q;
      overflow_d  = overflow_q;
      startVend   = 1'b0;
      takePending = 1'b0;
      finishVend  = 1'b0;

      case (state_q)
         IDLE: begin
            if (pendValid_q) begin
               takePending = 1'b1;
            end else if (vendEvent) begin
               state_d   = MOTOR;
               code_d    = out;
               coins_d   = change;
               cnt_d     = '0;
               startVend = 1'b1;
            end
         end
         MOTOR: begin
            if (cnt_q == MOTOR_LAST) begin
               if (coins_q != 2'd0) begin
                  state_d = EJECT;
                  cnt_d   = '0;
               end else begin
                  finishVend = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         EJECT: begin
            if (coin_ack) begin
               coins_d = coins_q - 2'd1;
               cnt_d   = '0;
               if (coins_q == 2'd1) begin
                  finishVend = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end else if (cnt_q == ACK_LAST) begin
               state_d = JAM;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = EJECT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         JAM: begin
            state_d = JAM;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (finishVend) begin
         if (pendValid_q) begin
            takePending = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end

      if (takePending) begin
         state_d     = MOTOR;
         code_d      = pendCode_q;
         coins_d     = pendCoins_q;
         cnt_d       = '0;
         startVend   = 1'b1;
         pendValid_d = 1'b0;
      end

      if (vendEvent && ((state_q != IDLE) || pendValid_q)) begin
         if (!pendValid_q || takePending) begin
            pendValid_d = 1'b1;
            pendCode_d  = out;
            pendCoins_d = change;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // State and status registers. busy and jam are registered from the
   // next-state values so they describe the controller after each edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_q       <= 3'd0;
         code_q      <= 3'd0;
         coins_q     <= 2'd0;
         cnt_q       <= '0;
         pendValid_q <= 1'b0;
         pendCode_q  <= 3'd0;
         pendCoins_q <= 2'd0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         jam_q       <= 1'b0;
         vendCount_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         out_q       <= out;
         code_q      <= code_d;
         coins_q     <= coins_d;
         cnt_q       <= cnt_d;
         pendValid_q <= pendValid_d;
         pendCode_q  <= pendCode_d;
         pendCoins_q <= pendCoins_d;
         overflow_q  <= overflow_d;
         busy_q      <= (state_d != IDLE) || pendValid_d;
         jam_q       <= (state_d == JAM);
         if (startVend) begin
            vendCount_q <= vendCount_q + 8'd1;
         end
      end
   end

   // Motor and ejector drives decode directly from the registered state.
   always_comb begin
      motor_en   = 4'b0000;
      coin_eject = 1'b0;
      if (state_q == MOTOR) begin
         case (code_q)
            3'd1:    motor_en = 4'b0001;
            3'd2:    motor_en = 4'b0010;
            3'd3:    motor_en = 4'b0100;
            3'd4:    motor_en = 4'b1000;
            default: motor_en = 4'b0000;
         endcase
      end
      if (state_q == EJECT) begin
         coin_eject = 1'b1;
      end
   end

   assign busy       = busy_q;
   assign jam        = jam_q;
   assign overflow   = overflow_q;
   assign vend_count = vendCount_q;

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// tb_vm_dispense_ctrl
// Directed bench for vm_dispense_ctrl. Stimulus pushes the expected motor
// pulses, eject pulses and jam onsets (with start cycle and length) into a
// queue; a monitor turns observed DUT pulses into the same records and
// compares them in order. A simple ejector model answers coin_eject after a
// programmable delay. Status outputs are also checked at chosen points.

module tb_vm_dispense_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] out;
   logic [1:0] change;
   logic       coin_ack = 1'b0;
   logic [3:0] motor_en;
   logic       coin_eject;
   logic       busy;
   logic       jam;
   logic       overflow;
   logic [7:0] vend_count;

   vm_dispense_ctrl #(
      .MOTOR_CYCLES(4),
      .COIN_GAP(2),
      .ACK_TIMEOUT(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .out(out),
      .change(change),
      .coin_ack(coin_ack),
      .motor_en(motor_en),
      .coin_eject(coin_eject),
      .busy(busy),
      .jam(jam),
      .overflow(overflow),
      .vend_count(vend_count)
   );

   always #5 clk = ~clk;

   // Cycle index: inputs driven at the negedge of cycle c are sampled at the
   // following posedge, and outputs seen at the negedge of cycle c belong to c.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;
      logic [3:0] val;
      int         start;
      int         len;
   } txn_t;

   txn_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   int   ackEnable = 0;
   int   ackDelay  = 0;
   int   ackHi     = 0;

   function automatic string kindName(int k);
      if (k == 0) return "motor";
      if (k == 1) return "eject";
      return "jam";
   endfunction

   task automatic expectTxn(int kind, logic [3:0] val, int start, int len);
      txn_t t;
      t.kind  = kind;
      t.val   = val;
      t.start = start;
      t.len   = len;
      expQ.push_back(t);
   endtask

   task automatic compareTxn(txn_t act);
      txn_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_%s: got val=%b start=%0d len=%0d, required nothing",
                  kindName(act.kind), act.val, act.start, act.len);
      end else begin
         e = expQ.pop_front();
         if (e.kind != act.kind || e.val != act.val || e.start != act.start || e.len != act.len) begin
            errors++;
            $display("[TB] FAIL scoreboard: got %s val=%b start=%0d len=%0d, required %s val=%b start=%0d len=%0d",
                     kindName(act.kind), act.val, act.start, act.len,
                     kindName(e.kind), e.val, e.start, e.len);
         end
      end
   endtask

   task automatic checkOutput(string name, logic [7:0] actual, logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(logic [2:0] o, logic [1:0] c, int cycles);
      out    = o;
      change = c;
      repeat (cycles) @(negedge clk);
   endtask

   // Monitor: reports each completed motor pulse, eject pulse and jam onset.
   logic [3:0] prevMotor = 4'b0000;
   int         motorStart = 0;
   logic       prevEject = 1'b0;
   int         ejectStart = 0;
   logic       prevJam = 1'b0;

   always @(negedge clk) begin
      txn_t a;
      if (motor_en !== prevMotor) begin
         if (prevMotor != 4'b0000) begin
            a.kind  = 0;
            a.val   = prevMotor;
            a.start = motorStart;
            a.len   = cyc - motorStart;
            compareTxn(a);
         end
         motorStart = cyc;
      end
      prevMotor = motor_en;

      if (coin_eject !== prevEject) begin
         if (prevEject) begin
            a.kind  = 1;
            a.val   = 4'b0000;
            a.start = ejectStart;
            a.len   = cyc - ejectStart;
            compareTxn(a);
         end
         ejectStart = cyc;
      end
      prevEject = coin_eject;

      if (jam && !prevJam) begin
         a.kind  = 2;
         a.val   = 4'b0000;
         a.start = cyc;
         a.len   = 0;
         compareTxn(a);
      end
      prevJam = jam;
   end

   // Ejector model: acks ackDelay cycles after coin_eject rises.
   always @(negedge clk) begin
      if (coin_eject && ackEnable != 0) begin
         coin_ack = (ackHi == ackDelay);
         ackHi++;
      end else begin
         coin_ack = 1'b0;
         ackHi    = 0;
      end
   end

   initial begin
      int c0;
      reset  = 1'b1;
      out    = 3'd0;
      change = 2'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset_motor_en", 8'(motor_en), 8'd0);
      checkOutput("reset_coin_eject", 8'(coin_eject), 8'd0);
      checkOutput("reset_busy", 8'(busy), 8'd0);
      checkOutput("reset_jam", 8'(jam), 8'd0);
      checkOutput("reset_overflow", 8'(overflow), 8'd0);
      checkOutput("reset_vend_count", vend_count, 8'd0);
      reset = 1'b0;
      applyStimulus(3'd0, 2'd0, 2);

      // Coffee, no change, code held for three cycles.
      $display("[TB] coffee without change");
      c0 = cyc;
      expectTxn(0, 4'b0001, c0 + 1, 4);
      applyStimulus(3'd1, 2'd0, 3);
      applyStimulus(3'd0, 2'd0, 1);
      checkOutput("coffee_busy_in_motor", 8'(busy), 8'd1);
      applyStimulus(3'd0, 2'd0, 4);
      checkOutput("coffee_busy_done", 8'(busy), 8'd0);
      checkOutput("coffee_vend_count", vend_count, 8'd1);

      // Snacks, one coin, ejector acks three cycles after the request rises.
      $display("[TB] snacks with one coin");
      ackEnable = 1;
      ackDelay  = 3;
      c0 = cyc;
      expectTxn(0, 4'b0010, c0 + 1, 4);
      expectTxn(1, 4'b0000, c0 + 5, 4);
      applyStimulus(3'd2, 2'd1, 1);
      applyStimulus(3'd0, 2'd0, 12);
      checkOutput("snacks_vend_count", vend_count, 8'd2);
      checkOutput("snacks_busy_done", 8'(busy), 8'd0);

      // Water, three coins, immediate acks.
      $display("[TB] water with three coins");
      ackDelay = 0;
      c0 = cyc;
      expectTxn(0, 4'b0100, c0 + 1, 4);
      expectTxn(1, 4'b0000, c0 + 5, 1);
      expectTxn(1, 4'b0000, c0 + 8, 1);
      expectTxn(1, 4'b0000, c0 + 11, 1);
      applyStimulus(3'd3, 2'd3, 1);
      applyStimulus(3'd0, 2'd0, 14);
      checkOutput("water_vend_count", vend_count, 8'd3);
      checkOutput("water_busy_done", 8'(busy), 8'd0);

      // Cooldrink with a dead ejector: jam after 15 unanswered cycles.
      $display("[TB] ejector jam");
      ackEnable = 0;
      c0 = cyc;
      expectTxn(0, 4'b1000, c0 + 1, 4);
      expectTxn(1, 4'b0000, c0 + 5, 15);
      expectTxn(2, 4'b0000, c0 + 20, 0);
      applyStimulus(3'd4, 2'd2, 1);
      applyStimulus(3'd0, 2'd0, 23);
      checkOutput("jam_flag", 8'(jam), 8'd1);
      checkOutput("jam_coin_eject", 8'(coin_eject), 8'd0);
      checkOutput("jam_motor_en", 8'(motor_en), 8'd0);
      checkOutput("jam_busy", 8'(busy), 8'd1);
      checkOutput("jam_vend_count", vend_count, 8'd4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("jam_cleared", 8'(jam), 8'd0);
      checkOutput("jam_reset_busy", 8'(busy), 8'd0);
      checkOutput("jam_reset_vend_count", vend_count, 8'd0);
      applyStimulus(3'd0, 2'd0, 2);

      // Queueing: snacks queued during coffee, water dropped.
      $display("[TB] pending slot and overflow");
      ackEnable = 1;
      ackDelay  = 0;
      c0 = cyc;
      expectTxn(0, 4'b0001, c0 + 1, 4);
      expectTxn(1, 4'b0000, c0 + 5, 1);
      expectTxn(1, 4'b0000, c0 + 8, 1);
      expectTxn(0, 4'b0010, c0 + 9, 4);
      expectTxn(1, 4'b0000, c0 + 13, 1);
      applyStimulus(3'd1, 2'd2, 1);
      applyStimulus(3'd0, 2'd0, 1);
      applyStimulus(3'd2, 2'd1, 1);
      applyStimulus(3'd0, 2'd0, 1);
      applyStimulus(3'd3, 2'd1, 1);
      applyStimulus(3'd0, 2'd0, 1);
      checkOutput("queue_overflow", 8'(overflow), 8'd1);
      applyStimulus(3'd0, 2'd0, 10);
      checkOutput("queue_vend_count", vend_count, 8'd2);
      checkOutput("queue_busy_done", 8'(busy), 8'd0);

      // Invalid code, then reset while ejecting with a vend pending.
      $display("[TB] invalid code and reset mid-eject");
      applyStimulus(3'd7, 2'd2, 2);
      applyStimulus(3'd0, 2'd0, 6);
      checkOutput("invalid_vend_count", vend_count, 8'd2);
      checkOutput("invalid_busy", 8'(busy), 8'd0);
      ackEnable = 0;
      c0 = cyc;
      expectTxn(0, 4'b0001, c0 + 1, 4);
      expectTxn(1, 4'b0000, c0 + 5, 2);
      applyStimulus(3'd1, 2'd3, 1);
      applyStimulus(3'd0, 2'd0, 1);
      applyStimulus(3'd2, 2'd1, 1);
      applyStimulus(3'd0, 2'd0, 3);
      checkOutput("midreset_eject_before", 8'(coin_eject), 8'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midreset_coin_eject", 8'(coin_eject), 8'd0);
      checkOutput("midreset_busy", 8'(busy), 8'd0);
      checkOutput("midreset_overflow", 8'(overflow), 8'd0);
      applyStimulus(3'd0, 2'd0, 8);
      checkOutput("midreset_no_pending_vend", vend_count, 8'd0);
      checkOutput("midreset_busy_after", 8'(busy), 8'd0);

      applyStimulus(3'd0, 2'd0, 3);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d outstanding records, required 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vm_dispense_ctrl.md
# vm_dispense_ctrl

Dispense and change-return controller on the output side of the vending machine `vm`. It watches the `out` and `change` buses that `vm` produces. For each vend, it pulses the selected product motor, then ejects the owed 10 Rs coins one at a time using a request/acknowledge handshake with the coin ejector. It queues one vend that arrives while busy, and flags ejector jams and lost vends.

## Interface
Parameters:
- MOTOR_CYCLES, 4: cycles each motor enable is held (≥1)
- COIN_GAP, 2: idle cycles between successive coin ejects (≥1)
- ACK_TIMEOUT, 15: eject cycles without `coin_ack` before declaring a jam (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- out  in  3  product code from `vm`: 0 none, 1 coffee, 2 snacks, 3 water, 4 cooldrink; 5–7 invalid
- change  in  2  number of 10 Rs coins to return (0–3), valid with `out`
- coin_ack  in  1  ejector accepted the current coin
- motor_en  out  4  one-hot; bit k-1 drives the motor for product k
- coin_eject  out  1  coin-eject request
- busy  out  1  state ≠ IDLE or pending slot full
- jam  out  1  sticky; ejector ack timeout
- overflow  out  1  sticky; vend dropped because pending slot was full
- vend_count  out  8  vends started, wraps 255→0

## Operation
- Registered `out_q` tracks the previous `out`.
- Vend event: `out` in 1..4 and `out_q` == 0. `out` and `change` are captured on the event cycle.
- Codes 5–7 never create an event and do not update `out_q`'s effect beyond normal tracking.
- States:
  - IDLE → MOTOR on an event, or on a pending entry.
  - MOTOR: `motor_en` = onehot(code) for MOTOR_CYCLES cycles. Then go to EJECT if coins > 0; otherwise to the next vend (if pending) or IDLE.
  - EJECT: `coin_eject` = 1.
    - If `coin_ack` is sampled high, decrement coins. If coins remain, go to GAP; if none remain, go to the next vend or IDLE.
    - If ACK_TIMEOUT cycles pass without `coin_ack`, go to JAM.
  - GAP: `coin_eject` = 0 for COIN_GAP cycles, then return to EJECT.
  - JAM: all `motor_en` = 0, `coin_eject` = 0, `jam` = 1. Left only by reset; the pending entry is held.
- Pending slot (depth 1):
  - An event arriving while state ≠ IDLE, or while the slot is full, is written to the slot if it is empty.
  - If the slot is full, the event is dropped and `overflow` is set to 1.
  - Slot consumed and refilled on the same cycle: the new event is stored and no overflow is flagged.
- "Next vend": if the pending slot is full on the exit cycle, go directly to MOTOR with the pending code and change, and clear the slot.
- `vend_count` increments on every cycle that enters MOTOR.
- `coin_ack` is ignored outside EJECT.

## Timing
- Reset (synchronous, checked on the clk edge):
  - All outputs go to 0: `motor_en`, `coin_eject`, `busy`, `jam`, `overflow`, `vend_count`.
  - State goes to IDLE; `out_q` = 0; the pending slot is cleared.
  - Reset mid-operation aborts the current vend immediately.
  - A nonzero `out` present on the first cycle after reset is treated as an event.
- Event in IDLE on cycle T:
  - `motor_en` is high on T+1 through T+MOTOR_CYCLES.
  - The first `coin_eject` is high on T+MOTOR_CYCLES+1.
- Ack handshake:
  - `coin_ack` sampled high on cycle A drops `coin_eject` on A+1.
  - The next eject rises on A+1+COIN_GAP.
  - An ack in the first eject cycle is valid.
- Jam: declared on the cycle the ACK_TIMEOUT-th consecutive un-acked eject cycle ends. `jam` = 1 and `coin_eject` = 0 from the following cycle.
- Back-to-back vends: from the last MOTOR or EJECT cycle, MOTOR for the pending vend starts on the next cycle with no IDLE cycle in between.
- `busy` is registered and reflects the state and pending slot after each edge.

## Test plan
- Reset, then coffee with no change: `out`=1, `change`=0 for 3 cycles. Expect `motor_en`=0001 for 4 cycles starting one cycle after the event, `coin_eject` never high, `vend_count`=1, `busy` back to 0.
- Snacks with 1 coin: `out`=2, `change`=1; ejector acks 3 cycles after `coin_eject` rises. Expect `motor_en`=0010 ×4, then a single eject held 4 cycles, then IDLE.
- Water with 3 coins: `out`=3, `change`=3; ack in the same cycle each time. Expect three 1-cycle eject pulses spaced by 2-cycle gaps.
- Jam: `out`=4, `change`=2; `coin_ack` held at 0. Expect `coin_eject` high for 15 cycles, then `jam`=1 and all outputs idle. Apply reset → `jam`=0.
- Queueing: start coffee (change 2). During its MOTOR phase, pulse `out` 0→2 (change 1), then 0→3. Expect snacks to run immediately after coffee's last eject, water dropped, `overflow`=1, `vend_count`=2.
- Reset mid-eject, and invalid code: `out`=7 produces no event. Reset asserted while `coin_eject`=1 → `coin_eject`=0 on the next cycle and the pending slot is cleared.
